// File: rtl/timer_dev_if.sv
// Bus-side port bundle of the countdown timer: word-select address, write
// strobe, store/load data and the interrupt line back to the CPU.
interface timer_dev_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  // Bus bridge / CPU side
  modport master (
    output addr,
    output we,
    output wdata,
    input  rdata,
    input  irq
  );

  // Timer side
  modport slave (
    input  addr,
    input  we,
    input  wdata,
    output rdata,
    output irq
  );
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped programmable countdown timer.
// Registers: 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (read-only), 3 reserved.
// Counts down from PRESET, sets a pending flag at zero; irq = pending & IM.
// MODE 01 reloads automatically (period PRESET+2); any other MODE is one-shot.
// Bus handshake: a write happens on every rising edge where we=1 (no ready/stall);
// rdata is a combinational function of addr and the current register state,
// so a read in a write cycle returns the old value.
module timer_dev #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CNT  = 2'd2;
  localparam logic [1:0] S_INT  = 2'd3;

  logic             en;
  logic [1:0]       mode;
  logic             im;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic [1:0]       state;
  logic             pend;

  logic             wr_ctrl;
  logic             wr_preset;
  logic             force_idle;
  logic             auto_mode;

  logic [1:0]       state_n;
  logic [CNT_W-1:0] count_n;
  logic             pend_set;
  logic             pend_auto_clr;
  logic             en_clr;
  logic [31:0]      preset_ext;
  logic [31:0]      count_ext;

  assign wr_ctrl    = bus.we && (bus.addr == 2'd0);
  assign wr_preset  = bus.we && (bus.addr == 2'd1);
  // Writing CTRL with EN=0 stops the timer from any state on the next edge.
  assign force_idle = wr_ctrl && !bus.wdata[0];
  assign auto_mode  = (mode == 2'b01);

  // Next-state / next-count decision for the countdown FSM
  always_comb begin
    state_n       = state;
    count_n       = count;
    pend_set      = 1'b0;
    pend_auto_clr = 1'b0;
    en_clr        = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) state_n = S_LOAD;
      end
      S_LOAD: begin
        count_n = preset;
        state_n = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_n = S_IDLE;
        end else if (count > CNT_W'(1)) begin
          count_n = count - CNT_W'(1);
        end else begin
          // Covers COUNT 0 and 1, so the counter can never wrap below zero.
          count_n  = '0;
          pend_set = 1'b1;
          state_n  = S_INT;
        end
      end
      default: begin
        if (auto_mode) begin
          pend_auto_clr = 1'b1;
          state_n       = S_LOAD;
        end else begin
          en_clr  = 1'b1;
          state_n = S_IDLE;
        end
      end
    endcase
    // A stop write freezes COUNT where it is.
    if (force_idle) begin
      state_n = S_IDLE;
      count_n = count;
    end
  end

  // FSM state and COUNT register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end

  // CTRL and PRESET registers; a CPU write to CTRL beats the one-shot EN clear
  always_ff @(posedge clk) begin
    if (reset) begin
      en     <= 1'b0;
      mode   <= 2'b00;
      im     <= 1'b0;
      preset <= '0;
    end else begin
      if (wr_ctrl) begin
        en   <= bus.wdata[0];
        mode <= bus.wdata[2:1];
        im   <= bus.wdata[3];
      end else if (en_clr) begin
        en <= 1'b0;
      end
      if (wr_preset) preset <= bus.wdata[CNT_W-1:0];
    end
  end

  // Pending flag: setting at terminal count wins over any clear in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
    end else if (pend_set) begin
      pend <= 1'b1;
    end else if (wr_ctrl || wr_preset || pend_auto_clr) begin
      pend <= 1'b0;
    end
  end

  // Zero-extend PRESET/COUNT to the 32-bit bus
  always_comb begin
    preset_ext              = '0;
    count_ext               = '0;
    preset_ext[CNT_W-1:0]   = preset;
    count_ext[CNT_W-1:0]    = count;
  end

  // Load data mux; CTRL[31:4] and the reserved word read as zero
  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      2'd0:    bus.rdata = {28'd0, im, mode, en};
      2'd1:    bus.rdata = preset_ext;
      2'd2:    bus.rdata = count_ext;
      default: bus.rdata = '0;
    endcase
  end

  assign bus.irq   = pend & im;
  assign state_dbg = state;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: cycle-accurate reads of CTRL/PRESET/COUNT
// and irq across one-shot, auto-reload, masked, stop/restart and reset cases.
module tb_timer_dev;

  localparam logic [1:0] S_IDLE = 2'd0;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;

  timer_dev_if bus_i ();

  timer_dev #(.CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_i.slave),
    .state_dbg (state_dbg)
  );

  int compared = 0;
  int mismatched = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_irq_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Advance to the start of the next cycle (just after the rising edge).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_i.addr  = a;
    bus_i.wdata = d;
    bus_i.we    = 1'b1;
    tick();
    bus_i.we    = 1'b0;
  endtask

  // Read in the current cycle: push expectations, sample at the falling edge.
  task automatic sample(input string tag, input logic [1:0] a,
                        input logic [31:0] exp_d, input logic exp_irq);
    logic [31:0] e;
    logic [31:0] ei;
    bus_i.addr = a;
    exp_q.push_back(exp_d);
    exp_irq_q.push_back({31'd0, exp_irq});
    @(negedge clk);
    e  = exp_q.pop_front();
    ei = exp_irq_q.pop_front();
    compared++;
    assert (bus_i.rdata === e) else begin
      mismatched++;
      $error("FAIL %s rdata: observed=%h expected=%h", tag, bus_i.rdata, e);
    end
    compared++;
    assert ({31'd0, bus_i.irq} === ei) else begin
      mismatched++;
      $error("FAIL %s irq: observed=%b expected=%b", tag, bus_i.irq, ei[0]);
    end
  endtask

  // Write and read the same register in one cycle; the read sees the old value.
  task automatic wr_chk(input string tag, input logic [1:0] a, input logic [31:0] d,
                        input logic [31:0] exp_old, input logic exp_irq);
    bus_i.wdata = d;
    bus_i.we    = 1'b1;
    sample(tag, a, exp_old, exp_irq);
    tick();
    bus_i.we    = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp_s);
    compared++;
    assert (state_dbg === exp_s) else begin
      mismatched++;
      $error("FAIL %s state: observed=%0d expected=%0d", tag, state_dbg, exp_s);
    end
  endtask

  // Expected COUNT c cycles after the enabling CTRL write (write cycle = 0).
  function automatic logic [31:0] model_count(input int c, input int start,
                                              input int pre, input bit auto_r);
    int k;
    if (c < 3) return 32'(start);
    k = c - 3;
    if (auto_r) k = k % (pre + 2);
    if (k < pre) return 32'(pre - k);
    return 32'd0;
  endfunction

  function automatic logic model_irq(input int c, input int pre,
                                     input bit auto_r, input bit im);
    if (!im || c < 3) return 1'b0;
    if (auto_r) return ((c - 3) % (pre + 2)) == pre;
    return c >= pre + 3;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    bus_i.addr  = 2'd0;
    bus_i.we    = 1'b0;
    bus_i.wdata = 32'd0;
    reset       = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state: every word reads 0, irq low, FSM idle
    for (int a = 0; a < 4; a++) begin
      sample($sformatf("reset_rd%0d", a), 2'(a), 32'd0, 1'b0);
      if (a == 0) chk_state("reset_state", S_IDLE);
      tick();
    end

    // One-shot, PRESET=5, IM set
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int c = 1; c <= 12; c++) begin
      sample($sformatf("oneshot_c%0d", c), 2'd2, model_count(c, 0, 5, 1'b0),
             model_irq(c, 5, 1'b0, 1'b1));
      tick();
    end
    sample("oneshot_ctrl_en_cleared", 2'd0, 32'h8, 1'b1);
    tick();
    wr(2'd0, 32'h0);
    sample("oneshot_irq_dropped", 2'd2, 32'd0, 1'b0);
    tick();

    // Auto-reload, PRESET=3, IM set: pulses in cycles 6, 11, 16
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int c = 1; c <= 17; c++) begin
      sample($sformatf("auto_c%0d", c), 2'd2, model_count(c, 0, 3, 1'b1),
             model_irq(c, 3, 1'b1, 1'b1));
      tick();
    end
    wr(2'd0, 32'h0);
    sample("auto_stopped_count", 2'd2, 32'd3, 1'b0);
    chk_state("auto_stopped_state", S_IDLE);
    tick();

    // Same as above with IM=0: identical COUNT, irq never asserts
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h3);
    for (int c = 1; c <= 17; c++) begin
      sample($sformatf("masked_c%0d", c), 2'd2, model_count(c, 3, 3, 1'b1), 1'b0);
      tick();
    end
    wr(2'd0, 32'h0);

    // PRESET=10, stop in cycle 6 freezes COUNT at 7
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    for (int c = 1; c <= 5; c++) begin
      sample($sformatf("stop_c%0d", c), 2'd2, model_count(c, 3, 10, 1'b0), 1'b0);
      tick();
    end
    wr(2'd0, 32'h0);
    sample("stop_frozen_c7", 2'd2, 32'd7, 1'b0);
    chk_state("stop_idle", S_IDLE);
    tick();
    sample("stop_frozen_c8", 2'd2, 32'd7, 1'b0);
    tick();

    // Restart reloads from PRESET; COUNT writes ignored; PRESET write mid-count deferred
    wr(2'd0, 32'h1);
    for (int c = 1; c <= 4; c++) begin
      sample($sformatf("restart_c%0d", c), 2'd2, model_count(c, 7, 10, 1'b0), 1'b0);
      tick();
    end
    wr(2'd2, 32'h1234);
    sample("count_write_ignored", 2'd2, 32'd7, 1'b0);
    tick();
    wr_chk("preset_old_on_write", 2'd1, 32'd2, 32'd10, 1'b0);
    sample("preset_write_no_count_effect", 2'd2, 32'd5, 1'b0);
    tick();
    sample("preset_new_value", 2'd1, 32'd2, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      sample($sformatf("midreset_rd%0d", a), 2'(a), 32'd0, 1'b0);
      tick();
    end

    // Reserved word and read-only CTRL bits
    wr(2'd3, 32'hDEAD_BEEF);
    sample("addr3_reads_zero", 2'd3, 32'd0, 1'b0);
    tick();
    wr(2'd0, 32'hFFFF_FFF8);
    sample("ctrl_upper_zero", 2'd0, 32'h8, 1'b0);
    tick();

    // PRESET=0 with MODE=10 (one-shot): irq from cycle 4, held; reset drops it
    wr(2'd0, 32'hD);
    for (int c = 1; c <= 3; c++) begin
      sample($sformatf("p0_c%0d", c), 2'd2, 32'd0, 1'b0);
      tick();
    end
    sample("p0_irq_c4", 2'd2, 32'd0, 1'b1);
    tick();
    sample("p0_ctrl_c5", 2'd0, 32'hC, 1'b1);
    tick();
    reset = 1'b1;
    sample("p0_reset_cycle", 2'd0, 32'hC, 1'b1);
    tick();
    reset = 1'b0;
    sample("p0_after_reset_ctrl", 2'd0, 32'd0, 1'b0);
    tick();
    sample("p0_after_reset_preset", 2'd1, 32'd0, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
